uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises one DATA_WIDTH-bit word per frame with a runtime baud divisor, selectable parity and 1 or 2 stop bits. Uses a valid/ready input handshake so an upstream FIFO or register bank can stream words back-to-back without idle gaps. Sits between the core's TX data source and the serial pin.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal range 5..9
DIV_WIDTH, 13, width of the runtime clocks-per-bit divisor

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset, asynchronous, active-low
tx_data  in  DATA_WIDTH  word to send, LSB transmitted first
tx_valid  in  1  tx_data is valid
tx_ready  out  1  block can accept a word this cycle
clks_per_bit  in  DIV_WIDTH  clock cycles per serial bit; 0 is treated as 1
parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (behaves as none)
two_stop  in  1  1 = two stop bits, 0 = one stop bit
txd  out  1  serial line, idle high, registered output
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (rstn low, any time, incl. mid-frame): state IDLE, txd=1, tx_ready=1, busy=0, done=0, all counters 0. Effect is immediate; the partial frame is abandoned, with no stop bit completed.
- Handshake: accept on a rising edge where tx_valid && tx_ready. At accept, latch tx_data, clks_per_bit, parity_mode and two_stop into shadow registers. Input changes during a frame have no effect.
- tx_ready = 1 only in IDLE. Input data must be held stable while tx_valid=1 && tx_ready=0.
- States: IDLE -> START -> DATA -> PARITY (only when parity enabled) -> STOP -> IDLE.
- IDLE: txd=1. On accept, go to START; txd=0 from the next cycle.
- Bit timing: each state/bit holds txd for exactly max(clks_per_bit,1) cycles. A bit-cycle counter runs from 0 to N-1, where N is the latched divisor. On N-1 the counter wraps to 0 and the block advances.
- DATA: sends bits 0..DATA_WIDTH-1. The bit index increments on each counter wrap. After bit DATA_WIDTH-1 wraps, go to PARITY or STOP.
- PARITY: even mode sends XOR of the data bits. Odd mode sends its inverse.
- STOP: txd=1 for N cycles (one stop bit) or 2N cycles (two stop bits).
- On the final STOP counter wrap: go to IDLE, and assert done for exactly that one cycle in IDLE. tx_ready=1 in the same cycle.
- Back-to-back: an accept in the done cycle drives txd low on the following cycle. The stop bit is followed directly by the next start bit, with no extra idle cycle.
- Frame length (accept edge to done cycle) = N*(1+DATA_WIDTH+P+S) cycles, where P = 1 if parity is enabled, else 0, and S = 1 or 2 (stop bits).
- Illegal state encodings recover to IDLE with txd=1 on the next clock.
- Counter widths: bit-cycle counter is DIV_WIDTH bits; bit index is ceil(log2(DATA_WIDTH)) bits. No overflow is possible for legal parameters.

Test Plan:
- clks_per_bit=4, parity 00, two_stop=0, send 0xA5. Required txd: 0 x4, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 x4. done pulses once, 40 cycles after the accept edge. tx_ready is low throughout the frame.
- clks_per_bit=2, send 0x07 with parity 01, then with parity 10. Required parity bit: 1 for even, 0 for odd. Frame is 22 cycles each.
- tx_valid held high with words 0x55 then 0xAA, two_stop=1, clks_per_bit=3. Required: two stop bits (6 high cycles), then the second start bit on the cycle after done. Exactly two accepts occur.
- clks_per_bit=0, send 0xFF, no parity. Required: each bit lasts 1 cycle and done arrives 10 cycles after accept.
- Change clks_per_bit from 4 to 8 and parity_mode mid-frame. Required: the current frame keeps N=4 and the original parity; the next frame uses the new values.
- Assert rstn low for 1 cycle during DATA bit 3. Required: txd=1, busy=0, tx_ready=1 immediately, no done pulse. A fresh accept afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DATA_WIDTH data bits, runtime baud divisor,
// optional even/odd parity, one or two stop bits, valid/ready word intake.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DIV_WIDTH-1:0]  clks_per_bit,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  last_cnt;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            pmode_q, pmode_d;
  logic                  two_q, two_d;
  logic                  txd_d, done_d;
  logic                  bit_end, parity_en, parity_bit;

  // A zero divisor behaves as one cycle per bit.
  assign last_cnt   = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
  assign bit_end    = (cnt_q == last_cnt);
  assign parity_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign parity_bit = (^data_q) ^ (pmode_q == 2'b10);

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    data_d  = data_q;
    div_d   = div_q;
    pmode_d = pmode_q;
    two_d   = two_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          data_d  = tx_data;
          div_d   = clks_per_bit;
          pmode_d = parity_mode;
          two_d   = two_stop;
          cnt_d   = '0;
          idx_d   = '0;
          stop2_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = parity_en ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // The first of two stop bits only re-arms the counter.
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        stop2_d = 1'b0;
      end
    endcase

    // The line level is decoded from the next state so txd stays registered.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_q[idx_d];
      PARITY:  txd_d = parity_bit;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop2_q <= 1'b0;
      data_q  <= '0;
      div_q   <= '0;
      pmode_q <= 2'b00;
      two_q   <= 1'b0;
      txd     <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      data_q  <= data_d;
      div_q   <= div_d;
      pmode_q <= pmode_d;
      two_q   <= two_d;
      txd     <= txd_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized frames for uart_tx_frame, checked cycle by cycle
// against a bit-list model of the serial waveform.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] clks_per_bit;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        txd;
  logic        busy;
  logic        done;

  int total   = 0;
  int bad     = 0;
  int accepts = 0;
  bit exp_wave[$];

  uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(13)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .clks_per_bit (clks_per_bit),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .txd          (txd),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && tx_valid && tx_ready) accepts <= accepts + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per clock, from accept edge to last stop cycle.
  task automatic build_frame(input logic [7:0] data, input int n, input logic [1:0] pm, input logic two);
    int reps;
    int ones;
    bit bits[$];
    reps = (n == 0) ? 1 : n;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pm == 2'b01) bits.push_back(ones % 2 == 1);
    else if (pm == 2'b10) bits.push_back(ones % 2 == 0);
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    exp_wave.delete();
    foreach (bits[i]) repeat (reps) exp_wave.push_back(bits[i]);
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input int n, input logic [1:0] pm,
                                input logic two, input bit hold);
    int waited;
    waited = 0;
    build_frame(data, n, pm, two);
    tx_data      = data;
    clks_per_bit = 13'(n);
    parity_mode  = pm;
    two_stop     = two;
    tx_valid     = 1'b1;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check_output("accept_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic check_frame(input int stop_at, input int chg_at,
                             input logic [12:0] new_n, input logic [1:0] new_pm);
    for (int k = 0; k < exp_wave.size(); k++) begin
      if (k == stop_at) return;
      @(negedge clk);
      check_output($sformatf("txd[%0d]", k), 32'(txd), 32'(exp_wave[k]));
      check_output($sformatf("ready[%0d]", k), 32'(tx_ready), 32'd0);
      check_output($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
      check_output($sformatf("done[%0d]", k), 32'(done), 32'd0);
      if (k == chg_at) begin
        clks_per_bit = new_n;
        parity_mode  = new_pm;
      end
    end
    @(negedge clk);
    check_output("done_pulse", 32'(done), 32'd1);
    check_output("done_ready", 32'(tx_ready), 32'd1);
    check_output("done_busy", 32'(busy), 32'd0);
    check_output("done_txd", 32'(txd), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [7:0] d;
    int n;
    logic [1:0] pm;
    logic two;

    rstn         = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    clks_per_bit = 13'd4;
    parity_mode  = 2'b00;
    two_stop     = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_txd", 32'(txd), 32'd1);
    check_output("rst_ready", 32'(tx_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] basic 8N1 frame 0xA5, N=4");
    apply_stimulus(8'hA5, 4, 2'b00, 1'b0, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);
    @(negedge clk);
    check_output("after_done", 32'(done), 32'd0);
    check_output("after_txd", 32'(txd), 32'd1);

    $display("[TB] parity even/odd on 0x07, N=2");
    apply_stimulus(8'h07, 2, 2'b01, 1'b0, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);
    apply_stimulus(8'h07, 2, 2'b10, 1'b0, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);

    $display("[TB] back-to-back 0x55 then 0xAA, two stop bits, N=3");
    @(negedge clk);
    base = accepts;
    apply_stimulus(8'h55, 3, 2'b00, 1'b1, 1'b1);
    tx_data = 8'hAA;
    check_frame(-1, -1, 13'd0, 2'b00);
    apply_stimulus(8'hAA, 3, 2'b00, 1'b1, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);
    check_output("accept_count", 32'(accepts - base), 32'd2);

    $display("[TB] divisor zero, 0xFF");
    apply_stimulus(8'hFF, 0, 2'b00, 1'b0, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);

    $display("[TB] config change mid-frame");
    apply_stimulus(8'h3C, 4, 2'b01, 1'b0, 1'b0);
    check_frame(-1, 10, 13'd8, 2'b10);
    apply_stimulus(8'h3C, 8, 2'b10, 1'b0, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);

    $display("[TB] reset during data bit 3");
    apply_stimulus(8'hC3, 4, 2'b00, 1'b0, 1'b0);
    check_frame(17, -1, 13'd0, 2'b00);
    rstn = 1'b0;
    #1;
    check_output("midrst_txd", 32'(txd), 32'd1);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_ready", 32'(tx_ready), 32'd1);
    check_output("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("postrst_done[%0d]", i), 32'(done), 32'd0);
      check_output($sformatf("postrst_txd[%0d]", i), 32'(txd), 32'd1);
    end
    apply_stimulus(8'h96, 4, 2'b01, 1'b1, 1'b0);
    check_frame(-1, -1, 13'd0, 2'b00);

    $display("[TB] randomized frames");
    for (int f = 0; f < 12; f++) begin
      d   = 8'($urandom);
      n   = int'($urandom_range(0, 5));
      pm  = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      apply_stimulus(d, n, pm, two, 1'b0);
      check_frame(-1, -1, 13'd0, 2'b00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
